// File: rtl/muldiv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sched_pkg
// Purpose  : Shared mul/div operation codes and scheduler state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_sched_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_MUL   = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } md_op_t;

    typedef logic [1:0] md_state_t;
    localparam md_state_t c_ST_IDLE = 2'd0;
    localparam md_state_t c_ST_BUSY = 2'd1;
    localparam md_state_t c_ST_DONE = 2'd2;

    typedef logic [1:0] md_unit_t;
    localparam md_unit_t c_UNIT_MUL   = 2'd0;
    localparam md_unit_t c_UNIT_DIV   = 2'd1;
    localparam md_unit_t c_UNIT_DZERO = 2'd2;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sched
// Purpose  : Sequences the shared multiplier/divider for both issue slots.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid_m,
    input  md_op_t            req_op_m,
    input  logic [XLEN-1:0]   req_a_m,
    input  logic [XLEN-1:0]   req_b_m,
    input  logic              req_valid_s,
    input  md_op_t            req_op_s,
    input  logic [XLEN-1:0]   req_a_s,
    input  logic [XLEN-1:0]   req_b_s,
    input  logic              ext_stall,
    input  logic              flush_ex,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic              op_signed,
    output logic              mul_start,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              div_start,
    output logic              div_cancel,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem,
    output logic              alu_stallE,
    output logic              res_valid_m,
    output logic [XLEN-1:0]   res_hi_m,
    output logic [XLEN-1:0]   res_lo_m,
    output logic              res_valid_s,
    output logic [XLEN-1:0]   res_hi_s,
    output logic [XLEN-1:0]   res_lo_s
);

    localparam int                 c_CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    md_state_t          r_state, w_state_nxt;
    md_unit_t           r_unit;
    md_op_t             r_op;
    logic               r_tag_s, r_pend, r_op_signed;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_op_a, r_op_b;
    logic               r_res_valid_m, r_res_valid_s;
    logic [XLEN-1:0]    r_res_hi_m, r_res_lo_m, r_res_hi_s, r_res_lo_s;

    logic               w_any_req, w_sel_s, w_sel_div, w_sel_dzero, w_launch;
    logic               w_cap_due, w_capture, w_chain, w_div_busy;
    md_op_t             w_sel_op;
    logic [XLEN-1:0]    w_sel_a, w_sel_b;
    logic [2*XLEN-1:0]  w_cap_val;

    // r_pend marks the cycle in which the slave is launched right after the master retires.
    assign w_any_req   = req_valid_m | req_valid_s;
    assign w_sel_s     = r_pend | ~req_valid_m;
    assign w_sel_op    = w_sel_s ? req_op_s : req_op_m;
    assign w_sel_a     = w_sel_s ? req_a_s  : req_a_m;
    assign w_sel_b     = w_sel_s ? req_b_s  : req_b_m;
    assign w_sel_div   = md_is_div(w_sel_op);
    assign w_sel_dzero = w_sel_div & (w_sel_b == '0);
    assign w_launch    = ~flush_ex & (((r_state == c_ST_IDLE) & w_any_req) | r_pend);

    // Operands bypass the holding register in the launch cycle so the units sample them with the pulse.
    assign op_a      = w_launch ? w_sel_a : r_op_a;
    assign op_b      = w_launch ? w_sel_b : r_op_b;
    assign op_signed = w_launch ? md_is_signed(w_sel_op) : r_op_signed;
    assign mul_start = w_launch & ~w_sel_div;
    assign div_start = w_launch & w_sel_div & ~w_sel_dzero;

    assign w_div_busy = (r_state == c_ST_BUSY) & ~r_pend & (r_unit == c_UNIT_DIV);
    assign div_cancel = flush_ex & w_div_busy;
    assign alu_stallE = ~flush_ex & (((r_state == c_ST_IDLE) & w_any_req) | (r_state == c_ST_BUSY));

    always_comb begin
        w_cap_due = 1'b0;
        w_cap_val = '0;
        if ((r_state == c_ST_BUSY) && !r_pend) begin
            case (r_unit)
                c_UNIT_MUL: begin
                    w_cap_due = (r_cnt == c_CNT_LAST);
                    w_cap_val = (r_op == MD_MUL) ? {{XLEN{1'b0}}, mul_result[XLEN-1:0]} : mul_result;
                end
                c_UNIT_DIV: begin
                    w_cap_due = div_done;
                    w_cap_val = {div_rem, div_quot};
                end
                default: begin
                    w_cap_due = 1'b1;
                    w_cap_val = {r_op_a, {XLEN{1'b1}}};
                end
            endcase
        end
    end

    assign w_capture = w_cap_due & ~flush_ex;
    assign w_chain   = w_capture & ~r_tag_s & req_valid_s;

    always_comb begin
        w_state_nxt = r_state;
        if (flush_ex) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (w_any_req)              w_state_nxt = c_ST_BUSY;
                c_ST_BUSY: if (w_capture && !w_chain)  w_state_nxt = c_ST_DONE;
                c_ST_DONE: if (!ext_stall)             w_state_nxt = c_ST_IDLE;
                default:                               w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_unit        <= c_UNIT_MUL;
            r_op          <= MD_MULT;
            r_tag_s       <= 1'b0;
            r_pend        <= 1'b0;
            r_op_signed   <= 1'b0;
            r_cnt         <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_res_valid_m <= 1'b0;
            r_res_valid_s <= 1'b0;
            r_res_hi_m    <= '0;
            r_res_lo_m    <= '0;
            r_res_hi_s    <= '0;
            r_res_lo_s    <= '0;
        end else begin
            if (w_launch) begin
                r_tag_s     <= w_sel_s;
                r_op        <= w_sel_op;
                r_op_a      <= w_sel_a;
                r_op_b      <= w_sel_b;
                r_op_signed <= md_is_signed(w_sel_op);
                r_unit      <= w_sel_dzero ? c_UNIT_DZERO : (w_sel_div ? c_UNIT_DIV : c_UNIT_MUL);
                r_cnt       <= c_CNT_LOAD;
                r_pend      <= 1'b0;
            end else if ((r_state == c_ST_BUSY) && (r_unit == c_UNIT_MUL) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                if (r_tag_s) begin
                    r_res_valid_s <= 1'b1;
                    r_res_hi_s    <= w_cap_val[2*XLEN-1:XLEN];
                    r_res_lo_s    <= w_cap_val[XLEN-1:0];
                end else begin
                    r_res_valid_m <= 1'b1;
                    r_res_hi_m    <= w_cap_val[2*XLEN-1:XLEN];
                    r_res_lo_m    <= w_cap_val[XLEN-1:0];
                end
            end
            if (w_chain) r_pend <= 1'b1;
            if (flush_ex || ((r_state == c_ST_DONE) && !ext_stall)) begin
                r_res_valid_m <= 1'b0;
                r_res_valid_s <= 1'b0;
                r_pend        <= 1'b0;
            end
        end
    end

    assign res_valid_m = r_res_valid_m;
    assign res_hi_m    = r_res_hi_m;
    assign res_lo_m    = r_res_lo_m;
    assign res_valid_s = r_res_valid_s;
    assign res_hi_s    = r_res_hi_s;
    assign res_lo_s    = r_res_lo_s;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sched
// Purpose  : Randomised self-checking bench for muldiv_sched with unit models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic        v;
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
    } job_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid_m, req_valid_s, ext_stall, flush_ex;
    md_op_t      req_op_m, req_op_s;
    logic [31:0] req_a_m, req_b_m, req_a_s, req_b_s;
    logic [31:0] op_a, op_b, div_quot, div_rem;
    logic        op_signed, mul_start, div_start, div_cancel, div_done, alu_stallE;
    logic [63:0] mul_result;
    logic        res_valid_m, res_valid_s;
    logic [31:0] res_hi_m, res_lo_m, res_hi_s, res_lo_s;

    always #5 clk = ~clk;

    muldiv_sched #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid_m(req_valid_m), .req_op_m(req_op_m), .req_a_m(req_a_m), .req_b_m(req_b_m),
        .req_valid_s(req_valid_s), .req_op_s(req_op_s), .req_a_s(req_a_s), .req_b_s(req_b_s),
        .ext_stall(ext_stall), .flush_ex(flush_ex),
        .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
        .mul_start(mul_start), .mul_result(mul_result),
        .div_start(div_start), .div_cancel(div_cancel), .div_done(div_done),
        .div_quot(div_quot), .div_rem(div_rem),
        .alu_stallE(alu_stallE),
        .res_valid_m(res_valid_m), .res_hi_m(res_hi_m), .res_lo_m(res_lo_m),
        .res_valid_s(res_valid_s), .res_hi_s(res_hi_s), .res_lo_s(res_lo_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cycle_abs = 0;
    always @(posedge clk) cycle_abs <= cycle_abs + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cycle_abs, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MUL);
    endfunction

    function automatic logic div_nz(input job_t j);
        return !is_mul(j.op) && (j.b != 32'd0);
    endfunction

    function automatic logic [63:0] job_result(input job_t j);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, qb;
        int unsigned     va, vb;
        logic [63:0]     p;
        sa = $signed(j.a); sb = $signed(j.b);
        ua = j.a;          ub = j.b;
        qa = j.a;          qb = j.b;
        va = j.a;          vb = j.b;
        p  = '0;
        if (!is_mul(j.op) && j.b == 32'd0) p = {j.a, 32'hFFFF_FFFF};
        else case (j.op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = ua * ub;
            MD_MUL:   begin p = sa * sb; p[63:32] = '0; end
            MD_DIV:   p = {32'(qa % qb), 32'(qa / qb)};
            default:  p = {32'(va % vb), 32'(va / vb)};
        endcase
        return p;
    endfunction

    int   div_lat = 1;
    job_t jm, js;
    int   st_m, cp_m, st_s, cp_s, last_cap, done_rel, end_rel, flush_rel, fin;
    int   cur_rel = 0;
    logic active = 1'b0;
    logic chk_en = 1'b0;

    function automatic int dur(input job_t j);
        if (is_mul(j.op)) return MUL_LAT;
        if (j.b == 32'd0) return 1;
        return div_lat;
    endfunction

    // ---------------- multiplier / divider models ----------------
    int          mul_due = -1, div_due = -1;
    logic [63:0] mul_val;
    logic [31:0] dq, dr;

    always @(negedge clk) begin
        if (mul_start) begin
            mul_due = cycle_abs + MUL_LAT;
            if (op_signed) mul_val = longint'($signed(op_a)) * longint'($signed(op_b));
            else           mul_val = {32'd0, op_a} * {32'd0, op_b};
        end
        if (div_start) begin
            div_due = cycle_abs + div_lat;
            if (op_b == 32'd0) begin dq = '0; dr = '0; end
            else if (op_signed) begin
                dq = 32'($signed(op_a) / $signed(op_b));
                dr = 32'($signed(op_a) % $signed(op_b));
            end else begin
                dq = op_a / op_b;
                dr = op_a % op_b;
            end
        end
        if (div_cancel) div_due = -1;
    end

    always @(posedge clk) begin
        #1;
        mul_result = (cycle_abs == mul_due) ? mul_val : {$urandom, $urandom};
        div_done   = (cycle_abs == div_due);
        div_quot   = div_done ? dq : $urandom;
        div_rem    = div_done ? dr : $urandom;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin : b_cmp
        logic        fl, e_st, e_ms, e_ds, e_dc, e_vm, e_vs;
        logic [63:0] rm, rs;
        int          r;
        if (chk_en) begin
            e_st = 0; e_ms = 0; e_ds = 0; e_dc = 0; e_vm = 0; e_vs = 0;
            rm = job_result(jm);
            rs = job_result(js);
            if (active) begin
                r    = cur_rel;
                fl   = (r == flush_rel);
                e_st = !fl && (r <= last_cap);
                e_ms = !fl && ((r == st_m && is_mul(jm.op)) || (r == st_s && is_mul(js.op)));
                e_ds = !fl && ((r == st_m && div_nz(jm)) || (r == st_s && div_nz(js)));
                e_dc = fl && ((div_nz(jm) && r > st_m && r <= cp_m) ||
                              (div_nz(js) && r > st_s && r <= cp_s));
                e_vm = jm.v && (r > cp_m);
                e_vs = js.v && (r > cp_s);
            end
            chk("alu_stallE", alu_stallE, e_st);
            chk("mul_start", mul_start, e_ms);
            chk("div_start", div_start, e_ds);
            chk("div_cancel", div_cancel, e_dc);
            chk("res_valid_m", res_valid_m, e_vm);
            chk("res_valid_s", res_valid_s, e_vs);
            if (e_vm) chk("res_m", {res_hi_m, res_lo_m}, rm);
            if (e_vs) chk("res_s", {res_hi_s, res_lo_s}, rs);
        end
    end

    // ---------------- stimulus ----------------
    function automatic job_t mk_job(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        job_t j;
        j.v = 1'b1; j.op = op; j.a = a; j.b = b;
        return j;
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.v  = 1'b1;
        j.op = md_op_t'($urandom_range(0, 4));
        j.a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        case ($urandom_range(0, 5))
            0:       j.b = 32'd0;
            1, 2:    j.b = 32'($urandom_range(1, 9));
            3:       j.b = -32'($urandom_range(1, 9));
            default: j.b = $urandom;
        endcase
        if (j.a == 32'h8000_0000 && j.b == 32'hFFFF_FFFF) j.b = 32'd1;
        return j;
    endfunction

    // flush_at: -1 none, -2 random cycle within the transaction, else that relative cycle
    task automatic run_txn(input job_t m, input job_t s, input int lat, input int hold, input int flush_at);
        @(posedge clk); #1;
        jm = m; js = s; div_lat = lat;
        st_m = -100; cp_m = -100; st_s = -100; cp_s = -100;
        if (m.v) begin st_m = 0; cp_m = dur(m); end
        if (s.v) begin st_s = m.v ? cp_m + 1 : 0; cp_s = st_s + dur(s); end
        last_cap  = s.v ? cp_s : cp_m;
        done_rel  = last_cap + 1;
        end_rel   = done_rel + hold;
        flush_rel = (flush_at == -2) ? int'($urandom_range(0, end_rel)) : flush_at;
        fin       = (flush_rel >= 0 && flush_rel <= end_rel) ? flush_rel : end_rel;
        for (int r = 0; r <= fin; r++) begin
            if (r > 0) begin @(posedge clk); #1; end
            cur_rel = r; active = 1'b1;
            req_valid_m = m.v; req_op_m = m.op; req_a_m = m.a; req_b_m = m.b;
            req_valid_s = s.v; req_op_s = s.op; req_a_s = s.a; req_b_s = s.b;
            flush_ex = (r == flush_rel);
            if (r >= done_rel) ext_stall = (r < end_rel);
            else               ext_stall = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            active = 1'b0;
            req_valid_m = 1'b0; req_valid_s = 1'b0;
            flush_ex  = ($urandom_range(0, 3) == 0);
            ext_stall = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cycle_abs);
        $fatal(1, "watchdog");
    end

    initial begin
        job_t none_j;
        none_j = '0;
        resetn = 1'b0;
        req_valid_m = 0; req_valid_s = 0; ext_stall = 0; flush_ex = 0;
        req_op_m = MD_MULT; req_op_s = MD_MULT;
        req_a_m = '0; req_b_m = '0; req_a_s = '0; req_b_s = '0;
        jm = '0; js = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", alu_stallE, 0);
        chk("rst_pulses", {mul_start, div_start, div_cancel}, 0);
        chk("rst_valid", {res_valid_m, res_valid_s}, 0);
        chk("rst_res", {res_hi_m, res_lo_m, res_hi_s, res_lo_s}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2);

        // MULT -3 x 5
        run_txn(mk_job(MD_MULT, -32'd3, 32'd5), none_j, 4, 0, -1);
        chk("pin_t1_done", done_rel, 3);
        @(negedge clk);
        chk("pin_t1_res", {res_hi_m, res_lo_m}, 64'hFFFF_FFFF_FFFF_FFF1);
        idle_cycles(1);

        // DIVU 100 / 7, divider takes 9 cycles
        run_txn(mk_job(MD_DIVU, 32'd100, 32'd7), none_j, 9, 0, -1);
        chk("pin_t2_done", done_rel, 10);
        @(negedge clk);
        chk("pin_t2_res", {res_hi_m, res_lo_m}, {32'd2, 32'd14});
        idle_cycles(1);

        // MULTU master with DIV slave
        run_txn(mk_job(MD_MULTU, 32'd7, 32'd2), mk_job(MD_DIV, 32'd7, 32'd2), 4, 0, -1);
        @(negedge clk);
        chk("pin_t3_res_m", {res_hi_m, res_lo_m}, {32'd0, 32'd14});
        chk("pin_t3_res_s", {res_hi_s, res_lo_s}, {32'd1, 32'd3});
        idle_cycles(1);

        // DIV flushed at cycle 4
        run_txn(mk_job(MD_DIV, 32'd50, 32'd3), none_j, 8, 0, 4);
        idle_cycles(2);

        // MUL with ext_stall held three cycles in DONE
        run_txn(mk_job(MD_MUL, 32'd6, 32'd7), none_j, 3, 3, -1);
        @(negedge clk);
        chk("pin_t5_res", {res_hi_m, res_lo_m}, {32'd0, 32'd42});
        idle_cycles(1);

        // divide by zero
        run_txn(mk_job(MD_DIV, 32'd9, 32'd0), none_j, 5, 0, -1);
        chk("pin_t6_done", done_rel, 2);
        @(negedge clk);
        chk("pin_t6_res", {res_hi_m, res_lo_m}, {32'd9, 32'hFFFF_FFFF});
        idle_cycles(1);

        for (int t = 0; t < 250; t++) begin
            job_t m, s;
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            m = rand_job(); s = rand_job();
            m.v = sel[0]; s.v = sel[1];
            run_txn(m, s, $urandom_range(1, 8), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? -2 : -1);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
